ram_arbiter_2p: RTL
===================

RAM_ARBITER_2P -- requirements
Module: ram_arbiter_2p

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the client and RAM data width.
REQ-002 Parameter ADDR_W, default 6, SHALL set the client and RAM address width (64 words).
REQ-003 Port clk, input, 1, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1, SHALL be the reset: asynchronous, active-low.
REQ-005 Ports a_req / b_req, input, 1, SHALL carry the client access request, held high until granted.
REQ-006 Ports a_we / b_we, input, 1, SHALL select the operation: 1 = write, 0 = read.
REQ-007 Ports a_addr / b_addr, input, ADDR_W, SHALL carry the client word address.
REQ-008 Ports a_wdata / b_wdata, input, DATA_W, SHALL carry the client write data.
REQ-009 Ports a_gnt / b_gnt, output, 1, SHALL pulse for one cycle when that client's request is issued to the RAM.
REQ-010 Ports a_rvalid / b_rvalid, output, 1, SHALL pulse for one cycle when read data for that client is on rdata.
REQ-011 Port rdata, output, DATA_W, SHALL carry the RAM read data shared by both clients.
REQ-012 Ports ram_we (1), ram_data (DATA_W), ram_write_addr (ADDR_W), ram_read_addr (ADDR_W), outputs, SHALL drive the single-port RAM.
REQ-013 Port ram_q, input, DATA_W, SHALL receive the RAM registered read output.

Function
REQ-014 The block SHALL issue at most one RAM operation per cycle.
REQ-015 A request SHALL be eligible at an edge when req=1 and that client's gnt is not already 1 in the current cycle.
REQ-016 The arbiter SHALL evaluate eligible requests at edge N, then drive gnt plus the registered RAM command for the winner during cycle N+1.
REQ-017 With a single eligible request, that client SHALL win.
REQ-018 With both requests eligible, round-robin SHALL apply: last_grant pointer reset to B, so A wins first; the winner becomes last_grant and the other client wins the next tie.
REQ-019 A write grant SHALL drive ram_we=1, ram_write_addr=addr and ram_data=wdata for exactly the grant cycle.
REQ-020 A read grant SHALL drive ram_we=0 and ram_read_addr=addr.
REQ-021 ram_read_addr SHALL hold its last value when no read is issued.
REQ-022 For a read granted in cycle N+1, the matching rvalid SHALL be 1 in cycle N+2 with rdata=ram_q, giving a 2-cycle req-to-data latency.
REQ-023 In idle cycles ram_we SHALL be 0, and ram_data and ram_write_addr SHALL hold their previous values.
REQ-024 Clients SHALL keep we, addr and wdata stable from req rise until gnt; req may stay high for back-to-back accesses, with the next request of the same client eligible at the edge ending the gnt cycle+1.
REQ-025 Under continuous contention, the grant sequence SHALL be A,B,A,B... with one grant per cycle and no starvation.
REQ-026 rdata SHALL be 0 in any cycle with no rvalid.

Reset
REQ-027 While rst_n=0, the outputs a_gnt, b_gnt, a_rvalid, b_rvalid and ram_we SHALL be 0.
REQ-028 While rst_n=0, the outputs ram_data, ram_write_addr, ram_read_addr and rdata SHALL be 0, and last_grant SHALL be B.
REQ-029 Reset asserted mid-transaction SHALL drop any pending read response; no rvalid SHALL follow reset release for a read granted before reset.
REQ-030 Arbitration SHALL resume at the first rising edge after rst_n deasserts.

Configuration
REQ-031 With macro ARB_FIXED_PRIORITY_EN defined, client A SHALL always win ties, B SHALL be granted only when A is not eligible, and last_grant SHALL be unused.
REQ-032 With ARB_FIXED_PRIORITY_EN undefined, the round-robin of REQ-018 SHALL apply.

Verification
REQ-033 Reset release, A write 8'hAA to addr 5 -> a_gnt=1 in cycle 2, and ram_we=1 / ram_write_addr=5 / ram_data=8'hAA in that same cycle.
REQ-034 After REQ-033, B read addr 5 -> b_gnt at +1, b_rvalid at +2 with rdata=8'hAA, a_rvalid=0.
REQ-035 A and B both write continuously (A: addr 10/8'hF0; B: addr 20/8'hB0) for 6 cycles -> gnt order A,B,A,B,A,B, with RAM addr 10 = 8'hF0 and addr 20 = 8'hB0.
REQ-036 Scenario of REQ-035 with ARB_FIXED_PRIORITY_EN -> B is granted only in cycles where A is ineligible (A,B,A,B from the gnt-cycle ineligibility of A).
REQ-037 A read addr 10 granted, rst_n=0 pulsed in the following cycle -> a_rvalid never asserts, all outputs are 0 during reset, and the first grant after release goes to A.

Source files
------------

// File: rtl/ram_arbiter_2p.sv
// Two-client arbiter in front of a single-port RAM with a registered read output.
// Round-robin by default; define ARB_FIXED_PRIORITY_EN to give client A strict priority.
module ram_arbiter_2p #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_rvalid,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_write_addr,
  output logic [ADDR_W-1:0] ram_read_addr,
  input  logic [DATA_W-1:0] ram_q
);

  logic              w_elig_a;
  logic              w_elig_b;
  logic              w_win_a;
  logic              w_win_b;
  logic              w_win;
  logic              w_win_we;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;
  logic              r_a_rd;
  logic              r_b_rd;

  // A client whose grant is showing this cycle sits out one edge.
  assign w_elig_a = a_req & ~a_gnt;
  assign w_elig_b = b_req & ~b_gnt;

`ifdef ARB_FIXED_PRIORITY_EN
  always_comb begin
    w_win_a = w_elig_a;
    w_win_b = w_elig_b & ~w_elig_a;
  end
`else
  typedef enum logic {
    LAST_A = 1'b0,
    LAST_B = 1'b1
  } last_t;

  last_t r_last;
  last_t w_last_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= LAST_B;
    end else begin
      r_last <= w_last_nxt;
    end
  end

  always_comb begin
    w_last_nxt = r_last;
    if (w_win_a) begin
      w_last_nxt = LAST_A;
    end else if (w_win_b) begin
      w_last_nxt = LAST_B;
    end
  end

  always_comb begin
    w_win_a = 1'b0;
    w_win_b = 1'b0;
    if (w_elig_a && w_elig_b) begin
      w_win_a = (r_last == LAST_B);
      w_win_b = (r_last == LAST_A);
    end else begin
      w_win_a = w_elig_a;
      w_win_b = w_elig_b;
    end
  end
`endif

  always_comb begin
    w_win       = w_win_a | w_win_b;
    w_win_we    = w_win_b ? b_we    : a_we;
    w_win_addr  = w_win_b ? b_addr  : a_addr;
    w_win_wdata = w_win_b ? b_wdata : a_wdata;
  end

  // Read responses ride a two-stage pipe aligned with the RAM's registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_gnt          <= 1'b0;
      b_gnt          <= 1'b0;
      r_a_rd         <= 1'b0;
      r_b_rd         <= 1'b0;
      a_rvalid       <= 1'b0;
      b_rvalid       <= 1'b0;
      ram_we         <= 1'b0;
      ram_data       <= '0;
      ram_write_addr <= '0;
      ram_read_addr  <= '0;
    end else begin
      a_gnt    <= w_win_a;
      b_gnt    <= w_win_b;
      r_a_rd   <= w_win_a & ~a_we;
      r_b_rd   <= w_win_b & ~b_we;
      a_rvalid <= r_a_rd;
      b_rvalid <= r_b_rd;
      ram_we   <= w_win & w_win_we;
      if (w_win && w_win_we) begin
        ram_write_addr <= w_win_addr;
        ram_data       <= w_win_wdata;
      end
      if (w_win && !w_win_we) begin
        ram_read_addr <= w_win_addr;
      end
    end
  end

  assign rdata = (a_rvalid | b_rvalid) ? ram_q : '0;

endmodule
